// File: rtl/crank_emu_pkg.sv
// Shared types and constants for the crank-wheel emulator.
package crank_emu_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } emu_state_e;

    localparam int PERIOD_MIN        = 2;
    localparam int TEETH_TOTAL_DEF   = 60;
    localparam int TEETH_MISSING_DEF = 2;
    localparam int LAST_REAL_TOOTH   = TEETH_TOTAL_DEF - TEETH_MISSING_DEF - 1;

    function automatic int last_real_tooth(input int total, input int missing);
        return total - missing - 1;
    endfunction
endpackage

// File: rtl/crank_emu_phase_cnt.sv
// Loadable modulo-P phase counter; wrap_o flags the last phase of a tooth.
module crank_emu_phase_cnt #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] period_i,
    output logic [W-1:0] phase_nxt_o,
    output logic         wrap_o
);
    logic [W-1:0] phase_q, phase_d;

    // >= keeps the counter bounded even if the period ever shrank below phase
    assign wrap_o = en_i && (phase_q >= period_i - W'(1));

    always_comb begin
        phase_d = phase_q;
        if (clr_i || wrap_o)
            phase_d = '0;
        else if (en_i)
            phase_d = phase_q + W'(1);
    end

    assign phase_nxt_o = phase_d;

    always_ff @(posedge clk) begin
        if (rst)
            phase_q <= '0;
        else
            phase_q <= phase_d;
    end
endmodule

// File: rtl/crank_wheel_emulator.sv
// Toothed crank-wheel waveform generator (60-2 by default).
// Optional cam phase output enabled with `define CRANK_EMU_CAM_EN.
module crank_wheel_emulator
    import crank_emu_pkg::*;
#(
    parameter int PERIOD_WIDTH  = 24,
    parameter int TEETH_TOTAL   = 60,
    parameter int TEETH_MISSING = 2,
    parameter int TOOTH_WIDTH   = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    period_wr,
    output logic                    crank_out,
    output logic [TOOTH_WIDTH-1:0]  tooth_num,
    output logic                    tooth_stb,
    output logic                    gap_stb,
    output logic                    busy,
    output logic                    cam_out
);
    localparam logic [TOOTH_WIDTH-1:0] LAST_TOOTH = TOOTH_WIDTH'(TEETH_TOTAL - 1);
    localparam logic [TOOTH_WIDTH-1:0] LAST_REAL  =
        TOOTH_WIDTH'(last_real_tooth(TEETH_TOTAL, TEETH_MISSING));
    localparam logic [PERIOD_WIDTH-1:0] PMIN = PERIOD_WIDTH'(PERIOD_MIN);

    emu_state_e                 state_q, state_d;
    logic [TOOTH_WIDTH-1:0]     tooth_q, tooth_d;
    logic [PERIOD_WIDTH-1:0]    per_q, per_d, shadow_q;
    logic [PERIOD_WIDTH-1:0]    phase_nxt;
    logic                       cnt_clr, cnt_en, cnt_wrap, new_tooth;
    logic                       run_d, crank_d, gap_d;
    logic                       crank_q, tstb_q, gap_q;

    crank_emu_phase_cnt #(.W(PERIOD_WIDTH)) u_phase (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .period_i   (per_q),
        .phase_nxt_o(phase_nxt),
        .wrap_o     (cnt_wrap)
    );

    always_comb begin
        state_d   = state_q;
        tooth_d   = tooth_q;
        per_d     = per_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        new_tooth = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena) begin
                    state_d   = RUN;
                    cnt_clr   = 1'b1;
                    tooth_d   = '0;
                    per_d     = shadow_q;
                    new_tooth = 1'b1;
                end
            end
            RUN, STOP: begin
                cnt_en  = 1'b1;
                state_d = ena ? RUN : STOP;
                // ena at the tooth's last phase decides: next tooth or idle
                if (cnt_wrap) begin
                    per_d = shadow_q;
                    if (ena) begin
                        new_tooth = 1'b1;
                        tooth_d   = (tooth_q == LAST_TOOTH) ? '0 : tooth_q + TOOTH_WIDTH'(1);
                    end else begin
                        state_d = IDLE;
                        tooth_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers take next-state values so they align with tooth_num.
    assign run_d   = (state_d != IDLE);
    assign crank_d = run_d && (tooth_d <= LAST_REAL) && (phase_nxt < (per_d >> 1));
    assign gap_d   = new_tooth && (tooth_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tooth_q  <= '0;
            per_q    <= PMIN;
            shadow_q <= PMIN;
            crank_q  <= 1'b0;
            tstb_q   <= 1'b0;
            gap_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tooth_q <= tooth_d;
            per_q   <= per_d;
            crank_q <= crank_d;
            tstb_q  <= new_tooth;
            gap_q   <= gap_d;
            if (period_wr)
                shadow_q <= (period < PMIN) ? PMIN : period;
        end
    end

    assign crank_out = crank_q;
    assign tooth_num = tooth_q;
    assign tooth_stb = tstb_q;
    assign gap_stb   = gap_q;
    assign busy      = (state_q != IDLE);

`ifdef CRANK_EMU_CAM_EN
    logic parity_q, parity_d, cam_q;

    assign parity_d = parity_q ^ gap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
            cam_q    <= 1'b0;
        end else begin
            parity_q <= parity_d;
            cam_q    <= run_d && (tooth_d == '0) && parity_d;
        end
    end

    assign cam_out = cam_q;
`else
    assign cam_out = 1'b0;
`endif
endmodule

// File: tb/tb_crank_wheel_emulator.sv
// Randomized bench for crank_wheel_emulator against a tooth/phase level model.
module tb_crank_wheel_emulator;
    localparam int PW = 24;
    localparam int TT = 60;
    localparam int TM = 2;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          rst, ena, period_wr;
    logic [PW-1:0] period;
    logic          crank_out, tooth_stb, gap_stb, busy, cam_out;
    logic [TW-1:0] tooth_num;

    always #5 clk = ~clk;

    crank_wheel_emulator #(
        .PERIOD_WIDTH (PW),
        .TEETH_TOTAL  (TT),
        .TEETH_MISSING(TM),
        .TOOTH_WIDTH  (TW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .period   (period),
        .period_wr(period_wr),
        .crank_out(crank_out),
        .tooth_num(tooth_num),
        .tooth_stb(tooth_stb),
        .gap_stb  (gap_stb),
        .busy     (busy),
        .cam_out  (cam_out)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int gq[$];

    // Model: wheel running flag, position within tooth, tooth index, periods, cam parity
    bit m_run = 0;
    int m_ph = 0, m_tn = 0, m_p = 2, m_sh = 2;
    bit m_par = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_chk++;
        if (obs === 32'(exp)) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_update();
        if (rst) begin
            m_run = 0; m_ph = 0; m_tn = 0; m_p = 2; m_sh = 2; m_par = 0;
            return;
        end
        if (!m_run) begin
            if (ena) begin
                m_run = 1; m_ph = 0; m_tn = 0; m_p = m_sh; m_par = !m_par;
            end
        end else if (m_ph == m_p - 1) begin
            if (ena) begin
                m_ph = 0; m_tn = (m_tn + 1) % TT; m_p = m_sh;
                if (m_tn == 0) m_par = !m_par;
            end else begin
                m_run = 0; m_ph = 0; m_tn = 0;
            end
        end else begin
            m_ph++;
        end
        // a write lands after this edge's boundary decision
        if (period_wr) m_sh = (period < 2) ? 2 : int'(period);
    endtask

    task automatic step();
        int e_cam;
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
`ifdef CRANK_EMU_CAM_EN
        e_cam = (m_run && m_tn == 0 && m_par) ? 1 : 0;
`else
        e_cam = 0;
`endif
        chk("crank", 32'(crank_out), (m_run && m_tn < TT - TM && m_ph < m_p / 2) ? 1 : 0);
        chk("tooth", 32'(tooth_num), m_run ? m_tn : 0);
        chk("tstb",  32'(tooth_stb), (m_run && m_ph == 0) ? 1 : 0);
        chk("gap",   32'(gap_stb),   (m_run && m_ph == 0 && m_tn == 0) ? 1 : 0);
        chk("busy",  32'(busy),      m_run ? 1 : 0);
        chk("cam",   32'(cam_out),   e_cam);
        if (gap_stb === 1'b1) gq.push_back(cyc);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic write_period(input int p);
        period = PW'(p); period_wr = 1'b1; step(); period_wr = 1'b0;
    endtask

    task automatic wait_pos(input int tn, input int ph);
        int i;
        for (i = 0; i < 2000 && !(m_run && m_tn == tn && m_ph == ph); i++) step();
        if (i == 2000) chk("wait_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; period = '0; period_wr = 1'b0;
        run(2);
        rst = 1'b0;
        run(2);

        // Start at P=10 and measure one full revolution between gap pulses
        write_period(10);
        ena = 1'b1;
        gq.delete();
        for (int i = 0; i < 2000 && gq.size() < 2; i++) step();
        if (gq.size() >= 2) chk("rev_len", 32'(gq[1] - gq[0]), 600);
        else chk("rev_timeout", 0, 1);

        // Period change mid-tooth takes effect at the next boundary
        wait_pos(7, 3);
        write_period(20);
        run(60);

        // Clamp and odd period
        write_period(1);
        run(300);
        write_period(7);
        run(500);

        // Stop mid-tooth, then restart
        write_period(10);
        run(50);
        wait_pos(4, 2);
        ena = 1'b0;
        run(20);
        ena = 1'b1;
        run(40);

        // Reset mid-tooth
        wait_pos(m_tn, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ena = 1'b0;
        run(5);

`ifdef CRANK_EMU_CAM_EN
        begin
            int cam_cnt = 0;
            rst = 1'b1; step(); rst = 1'b0;
            write_period(10);
            ena = 1'b1;
            for (int i = 0; i < 1200; i++) begin
                step();
                if (cam_out === 1'b1) cam_cnt++;
            end
            chk("cam_cnt", 32'(cam_cnt), 10);
            ena = 1'b0;
            run(12);
        end
`endif

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            ena       = ($urandom_range(0, 19) != 0);
            period_wr = ($urandom_range(0, 29) == 0);
            period    = PW'($urandom_range(0, 12));
            rst       = ($urandom_range(0, 799) == 0);
            step();
        end
        rst = 1'b0; ena = 1'b0; period_wr = 1'b0;
        run(30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
